// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte serializer among N_REQ requesters.
// Optional channel tag byte ahead of each burst: define UART_SCHED_CHAN_TAG_EN.
module uart_tx_sched #(
  parameter int N_REQ     = 4,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic [1:0]         grant_id,
  output logic               sched_busy,
  output logic               timeout_err
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
`ifdef UART_SCHED_CHAN_TAG_EN
    S_TAG,
`endif
    S_START,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  localparam logic [8:0]  BURST_LIM = 9'(BURST_MAX);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       pick, cand;
  logic [7:0]       burst_cnt_q, burst_cnt_d;
  logic [15:0]      to_cnt_q, to_cnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [7:0]       gnt_byte;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             tx_start_q, tx_start_d;
  logic             sched_busy_q, sched_busy_d;
  logic             timeout_err_q, timeout_err_d;
`ifdef UART_SCHED_CHAN_TAG_EN
  logic [7:0]       pay_q, pay_d;
  logic             tag_ph_q, tag_ph_d;
`endif

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (int'(id) == N_REQ - 1) ? 2'd0 : id + 2'd1;
  endfunction

  // Walk downwards so the nearest valid index at or after rr_q wins.
  always_comb begin
    pick = rr_q;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = 2'((int'(rr_q) + k) % N_REQ);
      if (req_valid[cand]) pick = cand;
    end
  end

  assign gnt_byte = req_data[{grant_id_q, 3'b000} +: 8];

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    rr_d          = rr_q;
    burst_cnt_d   = burst_cnt_q;
    to_cnt_d      = to_cnt_q;
    tx_data_d     = tx_data_q;
    timeout_err_d = 1'b0;
`ifdef UART_SCHED_CHAN_TAG_EN
    pay_d         = pay_q;
    tag_ph_d      = tag_ph_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          grant_id_d  = pick;
          burst_cnt_d = '0;
          state_d     = S_ACK;
        end
      end
      S_ACK: begin
        tx_data_d = gnt_byte;
        state_d   = S_START;
`ifdef UART_SCHED_CHAN_TAG_EN
        pay_d = gnt_byte;
        if (burst_cnt_q == '0) state_d = S_TAG;
`endif
      end
`ifdef UART_SCHED_CHAN_TAG_EN
      S_TAG: begin
        tx_data_d = 8'hA0 | {6'b0, grant_id_q};
        tag_ph_d  = 1'b1;
        state_d   = S_START;
      end
`endif
      S_START: begin
        to_cnt_d = '0;
        state_d  = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // A busy still high from a previous frame counts as the rise.
        if (tx_busy) begin
          state_d = S_WAIT_LO;
        end else begin
          to_cnt_d = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;
          if (to_cnt_d == TO_LAST) begin
            timeout_err_d = 1'b1;
            rr_d          = next_id(grant_id_q);
            state_d       = S_IDLE;
`ifdef UART_SCHED_CHAN_TAG_EN
            tag_ph_d      = 1'b0;
`endif
          end
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
`ifdef UART_SCHED_CHAN_TAG_EN
          if (tag_ph_q) begin
            tag_ph_d  = 1'b0;
            tx_data_d = pay_q;
            state_d   = S_START;
          end else
`endif
          begin
            burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
            if ((({1'b0, burst_cnt_q} + 9'd1) < BURST_LIM) && req_valid[grant_id_q]) begin
              state_d = S_ACK;
            end else begin
              rr_d    = next_id(grant_id_q);
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    req_ready_d  = (state_d == S_ACK) ? (N_REQ'(1) << grant_id_d) : '0;
    tx_start_d   = (state_d == S_START);
    sched_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_id_q    <= '0;
      rr_q          <= '0;
      burst_cnt_q   <= '0;
      to_cnt_q      <= '0;
      tx_data_q     <= 8'h00;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      sched_busy_q  <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef UART_SCHED_CHAN_TAG_EN
      pay_q         <= 8'h00;
      tag_ph_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      rr_q          <= rr_d;
      burst_cnt_q   <= burst_cnt_d;
      to_cnt_q      <= to_cnt_d;
      tx_data_q     <= tx_data_d;
      req_ready_q   <= req_ready_d;
      tx_start_q    <= tx_start_d;
      sched_busy_q  <= sched_busy_d;
      timeout_err_q <= timeout_err_d;
`ifdef UART_SCHED_CHAN_TAG_EN
      pay_q         <= pay_d;
      tag_ph_q      <= tag_ph_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign sched_busy  = sched_busy_q;
  assign timeout_err = timeout_err_q;

endmodule
